reg_dump_uart: RTL and testbench
================================

// Module: reg_dump_uart
// PURPOSE
//  Hardware read-out of the CPU register file: on a start pulse, reads x0..x(NUM_REGS-1)
//  through a register-file read port and streams each word over a UART 8N1 TX line.
//  Lets silicon runs be checked against the expected-register .mem files without a simulator.
//  Sits beside `registers` in `top`, driven from a halt/debug trigger; tx goes to the board pin.
// PARAMETERS
//  CLK_HZ     12_000_000  system clock frequency
//  BAUD       115200      UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (floor, 104 at defaults)
//  NUM_REGS   32          registers dumped, starting at x0 (1..32)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  reset    in   1   asynchronous, active-high reset
//  start    in   1   one-cycle request to begin a dump; ignored while busy
//  rf_addr  out  5   register-file read address
//  rf_data  in   32  register-file read data, valid the cycle after rf_addr changes
//  tx       out  1   UART serial output, idle high
//  busy     out  1   high from the cycle after an accepted start until done
//  done     out  1   one-cycle pulse when the final stop bit has completed
// BEHAVIOUR
//  Reset (async): tx=1, busy=0, done=0, rf_addr=0, FSM=IDLE, all counters 0.
//  FSM: IDLE -> FETCH -> LOAD -> SEND -> (NEXT_BYTE -> SEND)x3 -> NEXT_REG -> FETCH ... -> FINISH -> IDLE.
//   IDLE: start=1 -> rf_addr=0, busy=1, go FETCH.
//   FETCH: one wait cycle for rf_data.
//   LOAD: latch rf_data into 32-bit word register; byte_idx=0.
//   SEND: hand byte to serialiser; wait for its byte_done.
//   Byte order per register: big-endian, word[31:24] first. Bit order: LSB first.
//  Frame: start bit (0), 8 data bits, stop bit (1); each bit exactly CLKS_PER_BIT cycles.
//   Back-to-back frames within a dump: no extra idle between stop bit and next start bit
//   except the FETCH/LOAD cycles between registers (2 cycles of tx=1).
//  NEXT_REG: if rf_addr==NUM_REGS-1 -> FINISH, else rf_addr+1 -> FETCH. No wrap past NUM_REGS-1.
//  FINISH: done=1 for one cycle, busy=0 same cycle, rf_addr=0; next cycle IDLE.
//  start asserted in FINISH or any busy state: ignored, not queued.
//  start asserted in the same cycle done pulses: ignored; needs a new pulse once IDLE.
//  Reset mid-dump: tx forced high immediately (asynchronously), partial frame abandoned, no done.
//  Value read as-is: x0 is sent as whatever rf_data returns (expected 0x00000000).
//  Total dump length ≈ NUM_REGS*(4*10*CLKS_PER_BIT + 2) + 3 cycles (133,187 at defaults).
// STRUCTURE
//  Package uart_pkg: CLKS_PER_BIT function/localparam, frame length constant (10),
//   dump FSM state enum (IDLE, FETCH, LOAD, SEND, NEXT_BYTE, NEXT_REG, FINISH).
//  Sub-module uart_tx_byte: inputs clk, reset, data[7:0], valid; outputs tx, ready, byte_done;
//   owns baud counter and 4-bit bit index; accepts valid only when ready.
//  reg_dump_uart holds the dump FSM, byte_idx (2 bits), word register, rf_addr counter.
// TESTING
//  Reset: assert reset mid-sim -> tx=1, busy=0, done=0, rf_addr=0 within same cycle, no clk edge needed.
//  Single register: NUM_REGS=1, rf_data=0xA5C3_0F81, start -> tx decodes bytes A5,C3,0F,81 in order,
//   each bit 104 cycles wide, done pulses once, busy low after.
//  Full dump: model RF with x_i = 0x1000_0000+i -> receiver model captures 128 bytes matching,
//   rf_addr steps 0..31, done after ~133,187 cycles (±2).
//  Start while busy: pulse start at byte 5 of dump -> no restart, byte stream unchanged, single done.
//  Reset mid-frame: reset during bit 3 of register x7 byte 2 -> tx=1 immediately, no done;
//   new start afterwards dumps from x0 cleanly.
//  Baud check: CLK_HZ=1_000_000, BAUD=100_000 -> every bit exactly 10 cycles, frame 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, dump FSM states and byte helper for the
// register-file UART dumper.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int STOP_BIT   = FRAME_BITS - 1;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int CLKS_PER_BIT = clks_per_bit(12_000_000, 115_200);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_NEXT_BYTE,
    S_NEXT_REG,
    S_FINISH
  } dump_state_t;

  // Big-endian byte pick: idx 0 is word[31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] w,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Registered tx, LSB first, each bit CPB
// cycles. Needs CPB >= 2.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CPB = CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_WARN = CW'(CPB - 2);
  localparam logic [3:0]    BIT_STOP = 4'(STOP_BIT);

  logic          r_active;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic          r_tx;
  logic          w_last;
  logic          w_take;

  assign w_last = r_active && (r_bit == BIT_STOP)
                  && (r_cnt == CNT_LAST);
  // Ready in the last stop cycle too, so frames can abut.
  assign ready  = !r_active || w_last;
  assign w_take = valid && ready;
  // Early warning: one cycle before the stop bit ends.
  assign byte_done = r_active && (r_bit == BIT_STOP)
                     && (r_cnt == CNT_WARN);
  assign tx = r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_tx     <= 1'b1;
    end else if (w_take) begin
      r_active <= 1'b1;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_data   <= data;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        if (r_bit == BIT_STOP) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
          r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Streams x0..x(NUM_REGS-1) from a register-file read port
// over UART 8N1, big-endian per word.
module reg_dump_uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int         CPB      = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  dump_state_t r_state;
  dump_state_t w_next;
  logic [4:0]  r_addr;
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        w_valid;
  logic [7:0]  w_byte;
  logic        w_ready;
  logic        w_byte_done;

  uart_tx_byte #(.CPB(CPB)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .data      (w_byte),
    .valid     (w_valid & w_ready),
    .tx        (tx),
    .ready     (w_ready),
    .byte_done (w_byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NEXT_BYTE / NEXT_REG land on the final stop cycle,
  // so bytes abut and registers are split by FETCH+LOAD.
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_byte  = 8'h00;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD: begin
        w_valid = 1'b1;
        w_byte  = rf_data[31:24];
        w_next  = S_SEND;
      end
      S_SEND: begin
        if (w_byte_done)
          w_next = (r_idx == 2'd3) ? S_NEXT_REG : S_NEXT_BYTE;
      end
      S_NEXT_BYTE: begin
        w_valid = 1'b1;
        w_byte  = word_byte(r_word, r_idx + 2'd1);
        w_next  = S_SEND;
      end
      S_NEXT_REG:
        w_next = (r_addr == LAST_REG) ? S_FINISH : S_FETCH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_word <= '0;
      r_idx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_addr <= '0;
        S_LOAD: begin
          r_word <= rf_data;
          r_idx  <= '0;
        end
        S_NEXT_BYTE: r_idx <= r_idx + 2'd1;
        S_NEXT_REG:
          r_addr <= (r_addr == LAST_REG) ? 5'd0 : r_addr + 5'd1;
        default: ;
      endcase
    end
  end

  assign rf_addr = r_addr;
  assign busy    = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done    = (r_state == S_FINISH);

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: cycle-level expected waveform built
// from the frame rules, plus UART receivers on tx.
module tb_reg_dump_uart;

  localparam int CPB_A = 10;
  localparam int NR    = 32;
  localparam int CPB_B = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, tx_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] rfd_a;
  logic        rst_b, start_b, tx_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [31:0] rfd_b;

  logic [31:0] rf_a [NR];

  always @(posedge clk) rfd_a <= rf_a[addr_a];
  always @(posedge clk)
    rfd_b <= (addr_b == 5'd0) ? 32'hA5C3_0F81 : 32'hDEAD_BEEF;

  reg_dump_uart #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .NUM_REGS(NR)
  ) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a),
    .rf_addr(addr_a), .rf_data(rfd_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_uart #(
    .CLK_HZ(12_000_000), .BAUD(115_200), .NUM_REGS(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b),
    .rf_addr(addr_b), .rf_data(rfd_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] addr;
  } obs_t;

  obs_t       exp_q[$];
  logic [7:0] exp_bytes[$];
  int         model_len;
  int         done_cnt, done_cnt_b, rx_n;
  bit         b_fin = 1'b0;

  // Expected per-cycle outputs from the cycle start is raised
  // through the done cycle.
  task automatic build_dump();
    obs_t o;
    o = obs_t'{1'b1, 1'b0, 1'b0, 5'd0};
    exp_q.push_back(o);
    for (int r = 0; r < NR; r++) begin
      logic [31:0] w;
      w = rf_a[r];
      o = obs_t'{1'b1, 1'b1, 1'b0, 5'(r)};
      repeat (2) exp_q.push_back(o);
      for (int j = 0; j < 4; j++) begin
        logic [7:0] b;
        logic [9:0] fr;
        b = w[31-8*j -: 8];
        exp_bytes.push_back(b);
        fr = {1'b1, b, 1'b0};
        for (int f = 0; f < 10; f++) begin
          o.tx = fr[f];
          repeat (CPB_A) exp_q.push_back(o);
        end
      end
    end
    o = obs_t'{1'b1, 1'b0, 1'b1, 5'd0};
    exp_q.push_back(o);
    model_len = exp_q.size();
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (rst_a === 1'b0) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = obs_t'{1'b1, 1'b0, 1'b0, 5'd0};
      a = {tx_a, busy_a, done_a, addr_a};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_a @%0t: got tx=%b busy=%b done=%b addr=%0d, expected tx=%b busy=%b done=%b addr=%0d",
                 $time, a.tx, a.busy, a.done, a.addr,
                 e.tx, e.busy, e.done, e.addr);
      end
      if (done_a) done_cnt++;
    end
    if (rst_b === 1'b0 && done_b) done_cnt_b++;
  end

  int         rx_p = -1;
  logic [7:0] rx_sh;

  always @(negedge clk) begin
    if (rst_a !== 1'b0) rx_p = -1;
    else if (rx_p < 0) begin
      if (tx_a == 1'b0) rx_p = 0;
    end else begin
      rx_p++;
      if (rx_p == CPB_A / 2)
        chk("rx_start", tx_a, 1'b0);
      else if (rx_p > CPB_A && rx_p < 9 * CPB_A
               && rx_p % CPB_A == CPB_A / 2)
        rx_sh = {tx_a, rx_sh[7:1]};
      else if (rx_p == 9 * CPB_A + CPB_A / 2) begin
        chk("rx_stop", tx_a, 1'b1);
        if (exp_bytes.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_extra: got byte 0x%0h, expected none", rx_sh);
        end else chk("rx_byte", rx_sh, exp_bytes.pop_front());
        rx_n++;
        rx_p = -1;
      end
    end
  end

  task automatic run_until_idle(input int pulse_at);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      start_a = (n == pulse_at) || (exp_q.size() == 1);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: got %0d cycles, expected drain", n);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic rx_b(output logic [7:0] b, input bit first);
    int p, k;
    b = '0;
    k = 0;
    @(negedge clk);
    while (tx_b !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL b_rx_timeout: got no start bit, expected one");
      return;
    end
    p = 0;
    if (first) begin
      while (p < CPB_B - 1) begin @(negedge clk); p++; end
      chk("b_start_width", tx_b, 1'b0);
      @(negedge clk); p++;
      chk("b_bit0_edge", tx_b, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      while (p < CPB_B * (i + 1) + CPB_B / 2) begin
        @(negedge clk); p++;
      end
      b[i] = tx_b;
    end
    while (p < 9 * CPB_B + CPB_B / 2) begin @(negedge clk); p++; end
    chk("b_stop", tx_b, 1'b1);
  endtask

  initial begin : tb_b
    logic [7:0] got;
    logic [7:0] want [4];
    int k;
    want = '{8'hA5, 8'hC3, 8'h0F, 8'h81};
    start_b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_busy", busy_b, 1'b1);
    for (int j = 0; j < 4; j++) begin
      rx_b(got, j == 0);
      chk("b_byte", got, want[j]);
    end
    k = 0;
    while (done_b !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    chk("b_done_seen", done_b, 1'b1);
    chk("b_done_busy", busy_b, 1'b0);
    repeat (5) @(negedge clk);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_busy_after", busy_b, 1'b0);
    chk("b_tx_idle", tx_b, 1'b1);
    b_fin = 1'b1;
  end

  initial begin : tb_main
    int w;
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b0;
    done_cnt = 0;
    done_cnt_b = 0;
    rx_n = 0;
    for (int i = 0; i < NR; i++) rf_a[i] = 32'h1000_0000 + i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_addr", addr_a, 5'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    build_dump();
    chk("model_len", model_len, 12866);
    chk("model_first_byte", exp_bytes[0], 8'h10);
    chk("model_x0_low", exp_bytes[3], 8'h00);
    chk("model_last_byte", exp_bytes[127], 8'h1F);
    done_cnt = 0;
    rx_n = 0;
    start_a = 1'b1;
    run_until_idle(555);
    chk("dump1_bytes", rx_n, 128);
    chk("dump1_done", done_cnt, 1);

    rf_a[0] = 32'h0;
    for (int i = 1; i < NR; i++) rf_a[i] = $urandom();
    rf_a[7][10] = 1'b0;
    @(posedge clk); #1;
    build_dump();
    done_cnt = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3050) @(posedge clk);
    #3;
    chk("pre_rst_tx", tx_a, 1'b0);
    chk("pre_rst_busy", busy_a, 1'b1);
    chk("pre_rst_addr", addr_a, 5'd7);
    rst_a = 1'b1;
    exp_q.delete();
    exp_bytes.delete();
    #1;
    chk("mid_rst_tx", tx_a, 1'b1);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_addr", addr_a, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt, 0);

    for (int i = 1; i < NR; i++) rf_a[i] = $urandom();
    @(posedge clk); #1;
    build_dump();
    done_cnt = 0;
    rx_n = 0;
    start_a = 1'b1;
    run_until_idle(int'($urandom_range(20, 12000)));
    chk("dump3_bytes", rx_n, 128);
    chk("dump3_done", done_cnt, 1);

    w = 0;
    while (!b_fin && w < 10000) begin @(posedge clk); w++; end
    if (!b_fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL b_timeout: got unfinished, expected finished");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
